// File: rtl/bs_restore_pkg.sv
// Shared definitions for the shift-restore block: default widths, FSM states
// and the saturation words used when a zero-fill left shift overflows.
package bs_restore_pkg;

  localparam int BS_WIDTH = 10;
  localparam int BS_SHW   = 3;
  localparam int BS_RW    = (1 << BS_SHW) - 1;

  // Largest positive / most negative two's-complement words at BS_WIDTH
  localparam logic [BS_WIDTH-1:0] BS_SAT_POS = {1'b0, {(BS_WIDTH-1){1'b1}}};
  localparam logic [BS_WIDTH-1:0] BS_SAT_NEG = {1'b1, {(BS_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bs_state_e;

endpackage

// File: rtl/bs_restore_if.sv
// Request/result handshake bundle for bs_restore; the requester side uses the
// master modport, the restore block uses the slave modport.
interface bs_restore_if
  import bs_restore_pkg::*;
#(
  parameter int WIDTH = BS_WIDTH,
  parameter int SHW   = BS_SHW
);

  localparam int RW = (1 << SHW) - 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] q;
  logic [RW-1:0]    r;
  logic [SHW-1:0]   k;
  logic             fill;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] w;
  logic             sat;

  modport master (
    output in_valid, q, r, k, fill, out_ready,
    input  in_ready, out_valid, w, sat
  );

  modport slave (
    input  in_valid, q, r, k, fill, out_ready,
    output in_ready, out_valid, w, sat
  );

endinterface

// File: rtl/bs_restore.sv
// Undoes a right shift by shifting left one bit per cycle, either refilling the
// low bits from the residue (exact restore) or zero-filling with saturation.
module bs_restore
  import bs_restore_pkg::*;
#(
  parameter int WIDTH = BS_WIDTH,
  parameter int SHW   = BS_SHW
) (
  input  logic         clk,
  input  logic         rst_n,
  bs_restore_if.slave  bus
);

  localparam int RW = (1 << SHW) - 1;
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  bs_state_e        state_reg, state_next;
  logic [WIDTH-1:0] acc_reg;
  logic [RW-1:0]    res_reg;
  logic [SHW-1:0]   cnt_reg;
  logic             fill_reg;
  logic             sign_reg;
  logic             ovf_reg;
  logic             accept;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] a,
                                                input logic bit_in);
    return {a[WIDTH-2:0], bit_in};
  endfunction

  assign accept = bus.in_valid && (state_reg == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      acc_reg   <= '0;
      res_reg   <= '0;
      cnt_reg   <= '0;
      fill_reg  <= 1'b0;
      sign_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        acc_reg  <= bus.q;
        // Left-align the k residue bits so the next one to insert is always the MSB
        res_reg  <= bus.r << (SHW'(RW) - bus.k);
        cnt_reg  <= bus.k;
        fill_reg <= bus.fill;
        sign_reg <= bus.q[WIDTH-1];
        ovf_reg  <= 1'b0;
      end else if (state_reg == ST_SHIFT) begin
        acc_reg <= shift_in(acc_reg, fill_reg & res_reg[RW-1]);
        res_reg <= {res_reg[RW-2:0], 1'b0};
        cnt_reg <= cnt_reg - 1'b1;
        if (!fill_reg && (acc_reg[WIDTH-1] != acc_reg[WIDTH-2]))
          ovf_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept)
          state_next = (bus.k != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        if (cnt_reg == SHW'(1))
          state_next = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_reg == ST_IDLE);
    bus.out_valid = 1'b0;
    bus.w         = '0;
    bus.sat       = 1'b0;
    if (state_reg == ST_DONE) begin
      bus.out_valid = 1'b1;
      bus.sat       = ovf_reg;
      if (ovf_reg)
        bus.w = sign_reg ? SAT_NEG : SAT_POS;
      else
        bus.w = acc_reg;
    end
  end

endmodule

// File: tb/tb_bs_restore.sv
// Scoreboard bench for bs_restore: directed and random restores, output hold,
// back-to-back throughput and reset during an operation.
module tb_bs_restore;
  import bs_restore_pkg::*;

  typedef struct {
    logic [9:0] w;
    logic       sat;
    int         lat;
  } exp_t;

  typedef struct {
    logic [9:0] q;
    logic [6:0] r;
    logic [2:0] k;
    logic       fill;
    exp_t       e;
  } stim_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  bs_restore_if #(.WIDTH(BS_WIDTH), .SHW(BS_SHW)) bus ();

  bs_restore #(.WIDTH(BS_WIDTH), .SHW(BS_SHW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: left shift of q by k; zero-fill overflows when the top k+1 bits of q differ
  function automatic exp_t model(input logic [9:0] qv, input logic [6:0] rv,
                                 input int kv, input logic fv);
    exp_t       e;
    logic [9:0] mask;
    logic       ovf;
    mask = 10'((1 << kv) - 1);
    e.w  = qv << kv;
    ovf  = 1'b0;
    if (fv)
      e.w = e.w | ({3'b000, rv} & mask);
    else
      for (int i = 1; i <= kv; i++)
        if (qv[9-i] != qv[9]) ovf = 1'b1;
    if (ovf)
      e.w = qv[9] ? BS_SAT_NEG : BS_SAT_POS;
    e.sat = ovf;
    e.lat = kv + 1;
    return e;
  endfunction

  task automatic drive_req(input logic [9:0] qv, input logic [6:0] rv,
                           input logic [2:0] kv, input logic fv, input exp_t e);
    int n;
    sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.q = qv;
    bus.r = rv;
    bus.k = kv;
    bus.fill = fv;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.q = 10'($urandom);
    bus.r = 7'($urandom);
    bus.k = 3'($urandom);
    bus.fill = 1'($urandom);
  endtask

  // Called right after the accept edge; lat counts cycles from the accept cycle
  task automatic wait_out(output logic [9:0] gw, output logic gs,
                          output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) seen = 1'b1;
    end
    gw = bus.w;
    gs = bus.sat;
  endtask

  task automatic finish_out;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b required 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", bus.out_valid); end
    if (bus.w !== 10'h000) begin errors++; $display("FAIL reset_w: got %h required 000", bus.w); end
    if (bus.sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %0b required 0", bus.sat); end
    rst_n = 1'b1;
    $display("reset: in_ready=%0b out_valid=%0b w=%h sat=%0b", bus.in_ready, bus.out_valid, bus.w, bus.sat);
  endtask

  task automatic test_vectors;
    stim_t      st[$];
    stim_t      s;
    exp_t       e;
    logic [9:0] gw;
    logic       gs;
    int         lat;
    bit         seen;
    st.push_back('{10'h3F8, 7'h00, 3'd2, 1'b0, '{10'h3E0, 1'b0, 3}});
    st.push_back('{10'h100, 7'h00, 3'd1, 1'b0, '{10'h1FF, 1'b1, 2}});
    st.push_back('{10'h280, 7'h00, 3'd2, 1'b0, '{10'h200, 1'b1, 3}});
    st.push_back('{10'h00A, 7'h03, 3'd2, 1'b1, '{10'h02B, 1'b0, 3}});
    st.push_back('{10'h155, 7'h00, 3'd0, 1'b0, '{10'h155, 1'b0, 1}});
    st.push_back('{10'h0C0, 7'h05, 3'd3, 1'b1, '{10'h205, 1'b0, 4}});
    for (int i = 0; i < 10; i++) begin
      s.q = 10'($urandom);
      s.r = 7'($urandom);
      s.k = 3'($urandom);
      s.fill = 1'($urandom);
      s.e = model(s.q, s.r, int'(s.k), s.fill);
      st.push_back(s);
    end
    foreach (st[i]) begin
      drive_req(st[i].q, st[i].r, st[i].k, st[i].fill, st[i].e);
      e = sb.pop_front();
      wait_out(gw, gs, lat, seen);
      checks += 4;
      if (!seen) begin errors++; $display("FAIL vec%0d_out_valid: no out_valid within budget, required 1", i); end
      if (gw !== e.w) begin errors++; $display("FAIL vec%0d_w: got %h required %h", i, gw, e.w); end
      if (gs !== e.sat) begin errors++; $display("FAIL vec%0d_sat: got %0b required %0b", i, gs, e.sat); end
      if (lat != e.lat) begin errors++; $display("FAIL vec%0d_latency: got %0d required %0d", i, lat, e.lat); end
      $display("vec%0d: q=%h r=%h k=%0d fill=%0b -> w=%h sat=%0b lat=%0d", i, st[i].q, st[i].r, st[i].k, st[i].fill, gw, gs, lat);
      finish_out();
    end
  endtask

  task automatic test_hold;
    exp_t       e;
    logic [9:0] gw;
    logic       gs;
    int         lat;
    bit         seen;
    drive_req(10'h37F, 7'h00, 3'd3, 1'b0, model(10'h37F, 7'h00, 3, 1'b0));
    e = sb.pop_front();
    wait_out(gw, gs, lat, seen);
    bus.in_valid = 1'b1;
    bus.q = 10'h123;
    bus.k = 3'd0;
    for (int i = 0; i < 5; i++) begin
      checks += 4;
      if (bus.w !== e.w) begin errors++; $display("FAIL hold%0d_w: got %h required %h", i, bus.w, e.w); end
      if (bus.sat !== e.sat) begin errors++; $display("FAIL hold%0d_sat: got %0b required %0b", i, bus.sat, e.sat); end
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold%0d_in_ready: got %0b required 0", i, bus.in_ready); end
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold%0d_out_valid: got %0b required 1", i, bus.out_valid); end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks += 2;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_in_ready: got %0b required 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_out_valid: got %0b required 0", bus.out_valid); end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_no_queue: out_valid=%0b required 0", bus.out_valid); end
    $display("hold: w=%h sat=%0b held 5 cycles, released", e.w, e.sat);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   last_acc;
    int   n_acc;
    int   n_out;
    last_acc = -1;
    n_acc = 0;
    n_out = 0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.k = 3'd7;
    bus.q = 10'($urandom);
    bus.r = 7'($urandom);
    bus.fill = 1'($urandom);
    for (int cyc = 0; cyc < 45; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        e = sb.pop_front();
        n_out++;
        checks += 2;
        if (bus.w !== e.w) begin errors++; $display("FAIL b2b%0d_w: got %h required %h", n_out, bus.w, e.w); end
        if (bus.sat !== e.sat) begin errors++; $display("FAIL b2b%0d_sat: got %0b required %0b", n_out, bus.sat, e.sat); end
        $display("b2b out%0d: w=%h sat=%0b", n_out, bus.w, bus.sat);
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus.q, bus.r, 7, bus.fill));
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 9) begin errors++; $display("FAIL b2b_period: got %0d required 9", cyc - last_acc); end
        end
        last_acc = cyc;
        n_acc++;
      end
      @(posedge clk);
      #1;
      bus.q = 10'($urandom);
      bus.r = 7'($urandom);
      bus.fill = 1'($urandom);
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        e = sb.pop_front();
        n_out++;
        checks += 2;
        if (bus.w !== e.w) begin errors++; $display("FAIL b2b%0d_w: got %h required %h", n_out, bus.w, e.w); end
        if (bus.sat !== e.sat) begin errors++; $display("FAIL b2b%0d_sat: got %0b required %0b", n_out, bus.sat, e.sat); end
        $display("b2b out%0d: w=%h sat=%0b", n_out, bus.w, bus.sat);
      end
    end
    checks += 2;
    if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain: %0d results missing, required 0", sb.size()); end
    if (n_acc < 4) begin errors++; $display("FAIL b2b_accepts: got %0d required at least 4", n_acc); end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift;
    exp_t       e;
    logic [9:0] gw;
    logic       gs;
    int         lat;
    bit         seen;
    int         spurious;
    drive_req(10'h0F3, 7'h12, 3'd7, 1'b1, model(10'h0F3, 7'h12, 7, 1'b1));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    void'(sb.pop_front());
    #1;
    checks += 4;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %0b required 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %0b required 0", bus.out_valid); end
    if (bus.w !== 10'h000) begin errors++; $display("FAIL midrst_w: got %h required 000", bus.w); end
    if (bus.sat !== 1'b0) begin errors++; $display("FAIL midrst_sat: got %0b required 0", bus.sat); end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) spurious++;
    end
    checks++;
    if (spurious != 0) begin errors++; $display("FAIL midrst_no_output: out_valid seen %0d cycles, required 0", spurious); end
    drive_req(10'h2C5, 7'h4B, 3'd6, 1'b1, model(10'h2C5, 7'h4B, 6, 1'b1));
    e = sb.pop_front();
    wait_out(gw, gs, lat, seen);
    checks += 3;
    if (!seen) begin errors++; $display("FAIL midrst_after_valid: no out_valid, required 1"); end
    if (gw !== e.w) begin errors++; $display("FAIL midrst_after_w: got %h required %h", gw, e.w); end
    if (lat != e.lat) begin errors++; $display("FAIL midrst_after_latency: got %0d required %0d", lat, e.lat); end
    $display("reset mid-shift: discarded, next w=%h sat=%0b lat=%0d", gw, gs, lat);
    finish_out();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.q = '0;
    bus.r = '0;
    bus.k = '0;
    bus.fill = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_vectors();
    test_hold();
    test_back_to_back();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bs_restore.md
BS_RESTORE -- requirements
Module: bs_restore

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, data word width.
REQ-002 The block SHALL have parameter SHW, default 3, shift-amount width (max shift 2^SHW-1 = 7).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1, request present.
REQ-006 The block SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 The block SHALL have port q, input, WIDTH, two's-complement value produced by a right-shift stage.
REQ-008 The block SHALL have port r, input, 2^SHW-1, residue; r[k-1:0] holds the bits shifted out, LSB-aligned.
REQ-009 The block SHALL have port k, input, SHW, left-shift amount, 0..7.
REQ-010 The block SHALL have port fill, input, 1, 1 = refill from residue (exact restore), 0 = zero-fill with saturation.
REQ-011 The block SHALL have port out_valid, output, 1, result present.
REQ-012 The block SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-013 The block SHALL have port w, output, WIDTH, restored or left-shifted value.
REQ-014 The block SHALL have port sat, output, 1, result was saturated; valid with out_valid.

Function
REQ-015 The block SHALL use an FSM with states IDLE, SHIFT and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid && in_ready, latching q, r, k and fill, and clearing the overflow flag.
REQ-017 On accept the FSM SHALL go to SHIFT if k != 0, else to DONE.
REQ-018 In SHIFT, each cycle SHALL perform one 1-bit left shift of the accumulator and decrement the remaining count; after the k-th shift the FSM SHALL go to DONE.
REQ-019 Shift i (i = 0..k-1) SHALL insert r[k-1-i] at bit 0 when fill=1, else 0; with fill=1, after k shifts acc = {q[WIDTH-1-k:0], r[k-1:0]}.
REQ-020 With fill=0, overflow SHALL be set sticky whenever acc[WIDTH-1] != acc[WIDTH-2] before a shift.
REQ-021 In DONE, out_valid SHALL be 1; w SHALL equal the saturated value (latched q[WIDTH-1] ? 0x200 : 0x1FF for WIDTH=10) if overflow, else acc; sat SHALL equal overflow.
REQ-022 With fill=1, w SHALL be the raw accumulator and sat SHALL be 0, even if the sign bit changed.
REQ-023 Latency: out_valid SHALL rise exactly k+1 cycles after the accept edge; k=0 gives 1 cycle.
REQ-024 w and sat SHALL be held stable while out_valid && !out_ready; on out_valid && out_ready the FSM SHALL return to IDLE.
REQ-025 Input changes outside the accept cycle SHALL have no effect; in_valid during SHIFT or DONE SHALL be ignored, not queued.

Reset
REQ-026 While rst_n=0 the FSM SHALL be in IDLE with in_ready=1, out_valid=0, w=0, sat=0, the accumulator and count at 0.
REQ-027 Reset asserted mid-SHIFT or mid-DONE SHALL discard the operation with no out_valid afterwards; the first accept is possible on the first edge after deassertion.

Structure
REQ-028 WIDTH, SHW, the FSM state enum and the saturation constants SHALL live in the shared filter package.
REQ-029 The block SHALL be a single module without sub-modules; the 1-bit shift-with-insert step MAY be a local function.

Verification
REQ-030 q=0x3F8, k=2, fill=0 -> w=0x3E0, sat=0, out_valid 3 cycles after accept.
REQ-031 q=0x100, k=1, fill=0 -> w=0x1FF, sat=1; q=0x280, k=2, fill=0 -> w=0x200, sat=1.
REQ-032 q=0x00A, r=7'b0000011, k=2, fill=1 -> w=0x02B, sat=0.
REQ-033 q=0x155, k=0, fill=0 -> w=0x155, sat=0, out_valid 1 cycle after accept.
REQ-034 out_ready held 0 for 5 cycles in DONE -> w and sat stable, in_ready=0; out_ready=1 -> IDLE next cycle; back-to-back requests at k=7 take 9 cycles each.
REQ-035 rst_n pulsed low on the 3rd SHIFT cycle of a k=7 request -> all outputs at reset values, no out_valid, next request processed correctly.
